axi_write_burst: RTL
====================

Name: axi_write_burst

Overview:
AXI4 write master that converts an input data stream into fixed-length INCR bursts. It generates addresses itself, advancing through a circular region in memory. Successor to the single-burst stream writer: width, burst length and region are parameters, with short-frame padding and B-response checking. Sits between a stream source (FIFO/DMA front end) and an AXI interconnect slave port.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 64, data width; 32/64/128/256/512 only.
BURST_LEN, 16, beats per burst, 1..256; BURST_LEN*DATA_WIDTH/8 <= 4096.
BASE_ADDR, 32'h1000_0000, region start; aligned to burst bytes.
REGION_SIZE, 32'h0010_0000, region bytes; nonzero multiple of burst bytes.
RESTART_ON_LAST, 0, 1: the address pointer returns to BASE_ADDR after a burst containing s_tlast.

Ports:
m_axi_aclk  in  1  sole clock
m_axi_areset  in  1  synchronous active-high reset
s_wr_tdata  in  DATA_WIDTH  stream data
s_wr_tvalid  in  1  stream valid
s_wr_tlast  in  1  frame end
s_wr_tready  out  1  stream ready
m_axi_aw*  out  -  awid(1)=0, awaddr(ADDR_WIDTH), awlen(8)=BURST_LEN-1, awsize(3)=log2(DATA_WIDTH/8), awburst(2)=2'b01, awlock=0, awcache(4)=4'b0011, awprot(3)=0, awqos(4)=0, awvalid
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1
m_axi_wready  in  1
m_axi_bid/bresp/bvalid  in  1/2/1
m_axi_bready  out  1
busy  out  1  state != IDLE
err  out  1  sticky; set on any bresp != 2'b00
err_resp  out  2  bresp of the first error
burst_cnt  out  32  completed bursts (B handshakes), wraps at 2^32

Behaviour:
- Reset: state IDLE. awvalid, wvalid, wlast and bready are 0. wdata, wstrb, awaddr, err, err_resp and burst_cnt are 0. addr_ptr = BASE_ADDR. s_wr_tready = 0.
- FSM IDLE->ADDR->DATA->RESP->IDLE. One burst is outstanding at a time.
- IDLE: when s_wr_tvalid=1, go to ADDR on the next edge. Data is not consumed in IDLE.
- ADDR: awvalid=1 and awaddr=addr_ptr, both held stable until awready. On the handshake, awvalid drops on the next edge and the FSM enters DATA.
- DATA: the W output register loads when (!wvalid || wready); beat_cnt counts 0..BURST_LEN-1.
- s_wr_tready = (state==DATA) && !pad && (!wvalid || wready). This is combinational; there is no bubble under continuous wready.
- Accepted beat: wdata=tdata, wstrb=all ones, wvalid=1.
- Beat BURST_LEN-1: wlast=1. BURST_LEN=1 gives wlast on the only beat.
- s_wr_tlast accepted before beat BURST_LEN-1: set pad. The remaining beats are generated internally with wdata=0, wstrb=0, without waiting on s_wr_tvalid. pad clears at RESP.
- s_wr_tlast on beat BURST_LEN-1: normal burst, no pad.
- wlast handshake: wvalid and wlast drop (unless reloaded, which cannot happen: next load is in the next burst). Go to RESP.
- RESP: bready=1. On bvalid: burst_cnt+1; if bresp!=0 and err=0, set err and latch err_resp. The FSM still goes to IDLE; the burst is not retried.
- Address update at B handshake:
  - If tlast was seen this burst and RESTART_ON_LAST=1: addr_ptr = BASE_ADDR.
  - Otherwise addr_ptr += BURST_LEN*DATA_WIDTH/8. If the result >= BASE_ADDR+REGION_SIZE, addr_ptr = BASE_ADDR (wrap).
- awvalid and wvalid never depend combinationally on ready inputs.
- bid is ignored.
- Reset mid-burst: immediate return to reset values. No AXI completion is attempted; the system resets the slave alongside.
- Elaboration: illegal parameter combinations (width, burst >4 KB, misalignment) must cause $error.

Optional Feature:
AXI_WR_BYTE_SWAP_EN: when defined, byte order is reversed across the full DATA_WIDTH before wdata (byte i <- byte DATA_WIDTH/8-1-i), for any legal width. When undefined, wdata = s_wr_tdata unchanged. Padding beats stay zero either way.

Test Plan:
- Continuous tvalid, wready and awready=1, 64-bit, BURST_LEN=16, 64 beats: 4 bursts at 0x1000_0000/0080/0100/0180. The 16 beats of each burst are consecutive, wlast is on beat 15, and burst_cnt=4.
- REGION_SIZE=0x200, 5 bursts: the fifth awaddr is 0x1000_0000 (wrap).
- tlast on beat 5 of a 16-beat burst: beats 6..15 have wstrb=0x00 and wdata=0, and s_wr_tready=0 during them. With RESTART_ON_LAST=1, the next awaddr is BASE_ADDR.
- wready toggling 1/0 every cycle and awready delayed 7 cycles: awaddr and wdata are stable while unacknowledged, no beat is lost or duplicated, and the data sequence 0..31 matches at the slave.
- bresp=2'b10 on burst 2, then 2'b11 on burst 3: err=1 and err_resp=2'b10 persist; bursts continue and burst_cnt increments.
- Reset asserted mid-DATA (beat 7): next cycle awvalid=wvalid=0, busy=0, addr_ptr=BASE_ADDR. With AXI_WR_BYTE_SWAP_EN defined, tdata 0x0011223344556677 appears as wdata 0x7766554433221100.

Source files
------------

// File: rtl/axi_write_burst.sv
// AXI4 write master: packs a stream into fixed-length INCR bursts over a circular address region.
// Optional: define AXI_WR_BYTE_SWAP_EN to reverse the byte order of write data.
module axi_write_burst #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 64,
    parameter int                    BURST_LEN       = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] REGION_SIZE     = ADDR_WIDTH'(32'h0010_0000),
    parameter bit                    RESTART_ON_LAST = 1'b0
) (
    input  logic                    m_axi_aclk,
    input  logic                    m_axi_areset,
    input  logic [DATA_WIDTH-1:0]   s_wr_tdata,
    input  logic                    s_wr_tvalid,
    input  logic                    s_wr_tlast,
    output logic                    s_wr_tready,
    output logic                    m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic                    m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic                    busy,
    output logic                    err,
    output logic [1:0]              err_resp,
    output logic [31:0]             burst_cnt
);
    localparam int                  STRB_W      = DATA_WIDTH / 8;
    localparam int                  BURST_BYTES = BURST_LEN * STRB_W;
    localparam logic [8:0]          LAST_BEAT   = 9'(BURST_LEN - 1);
    localparam logic [8:0]          ALL_BEATS   = 9'(BURST_LEN);
    localparam logic [ADDR_WIDTH:0] BURST_INC   = (ADDR_WIDTH + 1)'(BURST_BYTES);
    localparam logic [ADDR_WIDTH:0] REGION_END  = {1'b0, BASE_ADDR} + {1'b0, REGION_SIZE};

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64 && DATA_WIDTH != 128 &&
        DATA_WIDTH != 256 && DATA_WIDTH != 512) begin : g_bad_width
        $error("axi_write_burst: DATA_WIDTH must be 32, 64, 128, 256 or 512");
    end
    if (BURST_LEN < 1 || BURST_LEN > 256 || BURST_BYTES > 4096) begin : g_bad_burst
        $error("axi_write_burst: BURST_LEN out of range or burst exceeds 4 KB");
    end
    if ((BASE_ADDR % ADDR_WIDTH'(BURST_BYTES)) != '0) begin : g_bad_base
        $error("axi_write_burst: BASE_ADDR not aligned to burst bytes");
    end
    if (REGION_SIZE == '0 || (REGION_SIZE % ADDR_WIDTH'(BURST_BYTES)) != '0) begin : g_bad_region
        $error("axi_write_burst: REGION_SIZE must be a nonzero multiple of burst bytes");
    end

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    function automatic logic [DATA_WIDTH-1:0] wr_data_map(input logic [DATA_WIDTH-1:0] d);
`ifdef AXI_WR_BYTE_SWAP_EN
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < STRB_W; i++) r[8*i +: 8] = d[8*(STRB_W-1-i) +: 8];
        return r;
`else
        return d;
`endif
    endfunction

    state_t                  state_q;
    logic                    awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q, addr_ptr_q, ptr_next_d;
    logic [ADDR_WIDTH:0]     ptr_inc_d;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic [8:0]              beat_cnt_q;
    logic                    pad_q, last_seen_q, err_q;
    logic [1:0]              err_resp_q;
    logic [31:0]             burst_cnt_q;
    logic                    all_loaded, w_slot, w_load;
    logic                    unused_bid;

    assign unused_bid = m_axi_bid;

    always_comb begin
        ptr_inc_d = {1'b0, addr_ptr_q} + BURST_INC;
        if (RESTART_ON_LAST && last_seen_q) ptr_next_d = BASE_ADDR;
        else if (ptr_inc_d >= REGION_END)   ptr_next_d = BASE_ADDR;
        else                                ptr_next_d = ptr_inc_d[ADDR_WIDTH-1:0];
    end

    // Once the final beat sits in the W register no further stream beat may be taken for this burst.
    assign all_loaded  = (beat_cnt_q == ALL_BEATS);
    assign w_slot      = (state_q == S_DATA) && !all_loaded && (!wvalid_q || m_axi_wready);
    assign s_wr_tready = w_slot && !pad_q;
    assign w_load      = w_slot && (pad_q || s_wr_tvalid);

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state_q     <= S_IDLE;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            bready_q    <= 1'b0;
            awaddr_q    <= '0;
            addr_ptr_q  <= BASE_ADDR;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            beat_cnt_q  <= '0;
            pad_q       <= 1'b0;
            last_seen_q <= 1'b0;
            err_q       <= 1'b0;
            err_resp_q  <= 2'b00;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (s_wr_tvalid) begin
                    state_q   <= S_ADDR;
                    awvalid_q <= 1'b1;
                    awaddr_q  <= addr_ptr_q;
                end
                S_ADDR: if (m_axi_awready) begin
                    awvalid_q <= 1'b0;
                    state_q   <= S_DATA;
                end
                S_DATA: begin
                    if (w_load) begin
                        wvalid_q   <= 1'b1;
                        wlast_q    <= (beat_cnt_q == LAST_BEAT);
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (pad_q) begin
                            wdata_q <= '0;
                            wstrb_q <= '0;
                        end else begin
                            wdata_q <= wr_data_map(s_wr_tdata);
                            wstrb_q <= '1;
                            if (s_wr_tlast) begin
                                last_seen_q <= 1'b1;
                                if (beat_cnt_q != LAST_BEAT) pad_q <= 1'b1;
                            end
                        end
                    end else if (wvalid_q && m_axi_wready) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        if (wlast_q) begin
                            state_q  <= S_RESP;
                            bready_q <= 1'b1;
                        end
                    end
                end
                S_RESP: if (m_axi_bvalid) begin
                    bready_q    <= 1'b0;
                    burst_cnt_q <= burst_cnt_q + 32'd1;
                    if (m_axi_bresp != 2'b00 && !err_q) begin
                        err_q      <= 1'b1;
                        err_resp_q <= m_axi_bresp;
                    end
                    addr_ptr_q  <= ptr_next_d;
                    pad_q       <= 1'b0;
                    last_seen_q <= 1'b0;
                    beat_cnt_q  <= '0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m_axi_awid    = 1'b0;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awlen   = 8'(BURST_LEN - 1);
    assign m_axi_awsize  = 3'($clog2(STRB_W));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awqos   = 4'b0000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign busy          = (state_q != S_IDLE);
    assign err           = err_q;
    assign err_resp      = err_resp_q;
    assign burst_cnt     = burst_cnt_q;
endmodule
